button_irq_ctrl: RTL and testbench

//   Conditions the four raw active-low push-buttons of the CPU environment and turns presses into

---
 rtl/button_irq_ctrl.sv | 119 +++++++++++
 tb/tb_button_irq_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_irq_ctrl.sv
// Button front end for the CPU: synchronise, debounce and edge-detect four active-low buttons,
// latch press events as pending, and raise one prioritised interrupt at a time via req/ack/done.
module button_irq_ctrl #(
  parameter int NBTN      = 4,
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] buttons,
  input  logic [NBTN-1:0] irq_mask,
  input  logic            irq_ack,
  input  logic            irq_done,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] pending,
  output logic            irq,
  output logic [1:0]      irq_id
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [NBTN-1:0]  sync_p0, sync_p1;
  logic [NBTN-1:0]  stable_p2, stable_p3;
  logic [CNT_W-1:0] cnt [NBTN];
  logic [NBTN-1:0]  press;
  logic [NBTN-1:0]  cand, ack_clr;
  state_t           state, state_n;
  logic [1:0]       id_n;

  // Lowest set index wins; bit 0 is the highest priority.
  function automatic logic [1:0] prio_pick(input logic [NBTN-1:0] c);
    logic [1:0] w;
    w = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (c[i]) w = 2'(i);
    end
    return w;
  endfunction

  // Stage p0/p1: two-flop synchroniser, released (1) out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= buttons;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce counters; p3 is the delayed stable level used for the press strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_p2 <= '1;
      stable_p3 <= '1;
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      stable_p3 <= stable_p2;
      for (int i = 0; i < NBTN; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          stable_p2[i] <= sync_p1[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign btn_level = ~stable_p2;
  assign press     = stable_p3 & ~stable_p2;
  assign cand      = pending & irq_mask;

  always_comb begin
    state_n = state;
    id_n    = irq_id;
    ack_clr = '0;
    case (state)
      IDLE: begin
        if (|cand) begin
          state_n = REQ;
          id_n    = prio_pick(cand);
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_n         = SVC;
          ack_clr[irq_id] = 1'b1;
        end else if (!irq_mask[irq_id]) begin
          state_n = IDLE;
        end
      end
      SVC: begin
        if (irq_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request stage: a press landing in the same cycle as its ack keeps pending set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      irq_id  <= '0;
      irq     <= 1'b0;
      pending <= '0;
    end else begin
      state   <= state_n;
      irq_id  <= id_n;
      irq     <= (state_n == REQ);
      pending <= (pending & ~ack_clr) | press;
    end
  end

endmodule

// File: tb/tb_button_irq_ctrl.sv
// Randomised and directed bench for button_irq_ctrl with a window-based reference model and a
// scoreboard of per-cycle output snapshots plus a queue of expected interrupt ids.
module tb_button_irq_ctrl;

  localparam int DB = 8;

  logic       clk;
  logic       reset;
  logic [3:0] buttons;
  logic [3:0] irq_mask;
  logic       irq_ack;
  logic       irq_done;
  logic [3:0] btn_level;
  logic [3:0] pending;
  logic       irq;
  logic [1:0] irq_id;

  button_irq_ctrl #(.NBTN(4), .DB_CYCLES(DB), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .buttons   (buttons),
    .irq_mask  (irq_mask),
    .irq_ack   (irq_ack),
    .irq_done  (irq_done),
    .btn_level (btn_level),
    .pending   (pending),
    .irq       (irq),
    .irq_id    (irq_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef enum {M_IDLE, M_REQ, M_SVC} mstate_t;
  mstate_t     m_st;
  logic [3:0]  m_stable;
  logic [3:0]  m_pend;
  logic [3:0]  m_press;
  logic [1:0]  m_id;
  logic [3:0]  raw_q[$];
  logic [1:0]  req_q[$];
  logic [10:0] snap_q[$];

  // A new level is accepted once the synchronised input (raw delayed two edges) has shown the
  // same value, different from the accepted level, over the last DB edges.
  task automatic model_step();
    logic [3:0] nstable, cand, aclr, npend, smp;
    logic       w, same, found;
    if (reset) begin
      m_st     = M_IDLE;
      m_stable = 4'hF;
      m_pend   = 4'h0;
      m_press  = 4'h0;
      m_id     = 2'd0;
      raw_q.delete();
      repeat (DB + 1) raw_q.push_back(4'hF);
    end else begin
      nstable = m_stable;
      for (int b = 0; b < 4; b++) begin
        smp  = raw_q[0];
        w    = smp[b];
        same = 1'b1;
        for (int j = 1; j < DB; j++) begin
          smp = raw_q[j];
          if (smp[b] != w) same = 1'b0;
        end
        if (same && (w != m_stable[b])) nstable[b] = w;
      end
      aclr = 4'h0;
      cand = m_pend & irq_mask;
      case (m_st)
        M_IDLE: begin
          if (cand != 4'h0) begin
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
              if (!found && cand[i]) begin
                m_id  = 2'(i);
                found = 1'b1;
              end
            end
            m_st = M_REQ;
            req_q.push_back(m_id);
          end
        end
        M_REQ: begin
          if (irq_ack) begin
            aclr[m_id] = 1'b1;
            m_st       = M_SVC;
          end else if (!irq_mask[m_id]) begin
            m_st = M_IDLE;
          end
        end
        M_SVC: begin
          if (irq_done) m_st = M_IDLE;
        end
        default: m_st = M_IDLE;
      endcase
      npend    = (m_pend & ~aclr) | m_press;
      m_press  = m_stable & ~nstable;
      m_stable = nstable;
      m_pend   = npend;
      raw_q.push_back(buttons);
      void'(raw_q.pop_front());
    end
    snap_q.push_back({~m_stable, m_pend, (m_st == M_REQ), m_id});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compare every cycle's outputs, and each new request's id against the id queue
  logic irq_prev = 1'b0;
  initial begin
    logic [10:0] s;
    logic [1:0]  rid;
    forever begin
      @(negedge clk);
      if (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        check("btn_level", btn_level, s[10:7]);
        check("pending", pending, s[6:3]);
        check("irq", irq, s[2]);
        check("irq_id", irq_id, s[1:0]);
      end
      if (irq && !irq_prev) begin
        check("req_expected", req_q.size() != 0, 1);
        if (req_q.size() != 0) begin
          rid = req_q.pop_front();
          check("req_id", irq_id, rid);
        end
      end
      irq_prev = irq;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic seen_irq;
  logic [3:0] seen_lvl, seen_pend;

  task automatic tick_track(input int n);
    repeat (n) begin
      tick(1);
      seen_irq  = seen_irq | irq;
      seen_lvl  = seen_lvl | btn_level;
      seen_pend = seen_pend | pending;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset    = 1'b1;
    buttons  = 4'hF;
    irq_mask = 4'h0;
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    tick(1);
    irq_done = 1'b0;
  endtask

  initial begin
    int b;
    reset    = 1'b1;
    buttons  = 4'hF;
    irq_mask = 4'h0;
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    tick(3);
    reset = 1'b0;
    check("rst_btn_level", btn_level, 4'h0);
    check("rst_pending", pending, 4'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_irq_id", irq_id, 2'd0);

    // Reset in the middle of a request
    irq_mask = 4'b0001;
    buttons  = 4'b1110;
    tick(12);
    check("s1_req_up", irq, 1'b1);
    @(negedge clk);
    #2;
    reset   = 1'b1;
    buttons = 4'hF;
    #1;
    check("s1_async_irq", irq, 1'b0);
    check("s1_async_pending", pending, 4'h0);
    tick(2);
    reset = 1'b0;
    tick(4);

    // Single press: level latency and request latency
    irq_mask = 4'b0001;
    buttons  = 4'b1110;
    tick(9);
    check("s2_level_early", btn_level, 4'h0);
    tick(1);
    check("s2_level_at10", btn_level, 4'b0001);
    tick(1);
    check("s2_irq_at11", irq, 1'b0);
    tick(1);
    check("s2_irq_at12", irq, 1'b1);
    check("s2_id", irq_id, 2'd0);
    buttons = 4'hF;
    pulse_ack();
    check("s2_ack_pending", pending, 4'h0);
    check("s2_ack_irq", irq, 1'b0);
    pulse_done();
    tick(2);
    check("s2_idle_irq", irq, 1'b0);
    tick(12);

    // Bounce shorter than the debounce window
    irq_mask  = 4'b0010;
    seen_irq  = 1'b0;
    seen_lvl  = 4'h0;
    seen_pend = 4'h0;
    for (int r = 0; r < 3; r++) begin
      buttons = 4'b1101;
      tick_track(5);
      buttons = 4'hF;
      tick_track(5);
    end
    tick_track(12);
    check("s3_irq_never", seen_irq, 1'b0);
    check("s3_level_never", seen_lvl, 4'h0);
    check("s3_pending_never", seen_pend, 4'h0);

    // Simultaneous presses: lower index first
    irq_mask = 4'hF;
    buttons  = 4'b0101;
    tick(12);
    check("s4_irq_first", irq, 1'b1);
    check("s4_id_first", irq_id, 2'd1);
    buttons = 4'hF;
    pulse_ack();
    check("s4_ack_irq", irq, 1'b0);
    check("s4_ack_pending", pending, 4'b1000);
    pulse_done();
    check("s4_done_irq", irq, 1'b0);
    tick(1);
    check("s4_irq_second", irq, 1'b1);
    check("s4_id_second", irq_id, 2'd3);
    pulse_ack();
    pulse_done();
    tick(12);
    check("s4_pending_clear", pending, 4'h0);

    // Masked press stays pending; unmask raises, re-mask drops
    irq_mask = 4'h0;
    buttons  = 4'b1011;
    tick(12);
    check("s5_masked_pending", pending, 4'b0100);
    check("s5_masked_irq", irq, 1'b0);
    irq_mask = 4'b0100;
    tick(1);
    check("s5_unmask_irq", irq, 1'b1);
    check("s5_unmask_id", irq_id, 2'd2);
    irq_mask = 4'h0;
    tick(1);
    check("s5_remask_irq", irq, 1'b0);
    check("s5_remask_pending", pending, 4'b0100);
    do_reset();
    tick(2);

    // Ack colliding with a fresh press on the same button
    irq_mask = 4'b0001;
    buttons  = 4'b1110;
    tick(12);
    check("s6_irq", irq, 1'b1);
    buttons = 4'hF;
    tick(12);
    buttons = 4'b1110;
    tick(10);
    pulse_ack();
    check("s6_pending_kept", pending, 4'b0001);
    check("s6_ack_irq", irq, 1'b0);
    pulse_done();
    check("s6_done_irq", irq, 1'b0);
    tick(1);
    check("s6_second_irq", irq, 1'b1);
    check("s6_second_id", irq_id, 2'd0);
    pulse_ack();
    pulse_done();
    check("s6_pending_clear", pending, 4'h0);
    buttons = 4'hF;
    tick(15);

    // Random traffic
    irq_mask = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) begin
        b = $urandom_range(0, 3);
        buttons[b] = ~buttons[b];
      end
      if ($urandom_range(0, 99) == 0) irq_mask = 4'($urandom);
      irq_ack  = irq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      irq_done = ($urandom_range(0, 5) == 0);
      tick(1);
    end
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    irq_mask = 4'h0;
    buttons  = 4'hF;
    tick(20);
    @(negedge clk);
    #1;
    check("req_queue_drained", req_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
